// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - saturating dot-product accumulator with a decoupled output register
module mac_accumulator #(
    parameter int MUL_WIDTH = 32,
    parameter int ACC_WIDTH = 40,
    parameter int VEC_LEN   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MUL_WIDTH-1:0] mul_in,
    input  logic                 mul_valid,
    output logic                 mul_ready,
    input  logic                 flush,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_sat,
    output logic                 acc_valid,
    input  logic                 acc_ready
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);
    localparam logic [ACC_WIDTH-1:0] MAX_V = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] MIN_V = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] sum;
    logic                 sat_r;

    logic                 is_last;
    logic                 take;
    logic                 clamp;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH-1:0] addend;
    logic [ACC_WIDTH:0]   sum_w;
    logic [ACC_WIDTH-1:0] result;

    assign is_last   = (cnt == LAST);
    // Only the closing product of a vector needs the output register free.
    assign mul_ready = !rst && !flush && !(is_last && acc_valid && !acc_ready);
    assign take      = mul_valid && mul_ready;

    always_comb begin
        base   = (cnt == '0) ? '0 : sum;
        addend = {{(ACC_WIDTH-MUL_WIDTH){mul_in[MUL_WIDTH-1]}}, mul_in};
        sum_w  = {base[ACC_WIDTH-1], base} + {addend[ACC_WIDTH-1], addend};
        // Exact sum leaves the ACC_WIDTH range when the two top bits disagree.
        clamp  = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
        if (!clamp) begin
            result = sum_w[ACC_WIDTH-1:0];
        end else if (sum_w[ACC_WIDTH]) begin
            result = MIN_V;
        end else begin
            result = MAX_V;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            sum       <= '0;
            sat_r     <= 1'b0;
            acc_out   <= '0;
            acc_sat   <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            if (acc_valid && acc_ready) begin
                acc_valid <= 1'b0;
            end
            if (flush) begin
                cnt   <= '0;
                sat_r <= 1'b0;
            end else if (take) begin
                if (is_last) begin
                    acc_out   <= result;
                    acc_sat   <= sat_r | clamp;
                    acc_valid <= 1'b1;
                    cnt       <= '0;
                    sat_r     <= 1'b0;
                end else begin
                    sum   <= result;
                    sat_r <= sat_r | clamp;
                    cnt   <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized and directed bench for mac_accumulator against a queue-based model
module tb_mac_accumulator;

    localparam int MW   = 32;
    localparam int AW_A = 33;
    localparam int VL_A = 4;
    localparam int AW_S = 40;
    localparam int VL_S = 300;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [MW-1:0]   a_mul_in;
    logic            a_mul_valid, a_mul_ready, a_flush;
    logic [AW_A-1:0] a_acc_out;
    logic            a_acc_sat, a_acc_valid, a_acc_ready;

    logic [MW-1:0]   s_mul_in;
    logic            s_mul_valid, s_mul_ready, s_flush;
    logic [AW_S-1:0] s_acc_out;
    logic            s_acc_sat, s_acc_valid, s_acc_ready;

    mac_accumulator #(.MUL_WIDTH(MW), .ACC_WIDTH(AW_A), .VEC_LEN(VL_A)) dut_a (
        .clk(clk), .rst(rst),
        .mul_in(a_mul_in), .mul_valid(a_mul_valid), .mul_ready(a_mul_ready),
        .flush(a_flush),
        .acc_out(a_acc_out), .acc_sat(a_acc_sat), .acc_valid(a_acc_valid), .acc_ready(a_acc_ready)
    );

    mac_accumulator #(.MUL_WIDTH(MW), .ACC_WIDTH(AW_S), .VEC_LEN(VL_S)) dut_s (
        .clk(clk), .rst(rst),
        .mul_in(s_mul_in), .mul_valid(s_mul_valid), .mul_ready(s_mul_ready),
        .flush(s_flush),
        .acc_out(s_acc_out), .acc_sat(s_acc_sat), .acc_valid(s_acc_valid), .acc_ready(s_acc_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Dot product with clamping after every addition and a sticky saturation flag.
    function automatic void ref_vec(input longint p[$], input int aw, output longint res, output bit sat);
        longint mx;
        longint mn;
        longint s;
        mx  = (longint'(1) <<< (aw - 1)) - 1;
        mn  = -mx - 1;
        s   = 0;
        sat = 1'b0;
        foreach (p[i]) begin
            s = s + p[i];
            if (s > mx) begin
                s = mx;
                sat = 1'b1;
            end else if (s < mn) begin
                s = mn;
                sat = 1'b1;
            end
        end
        res = s;
    endfunction

    longint cur[$];
    longint exp_out[$];
    bit     exp_sat[$];
    longint obs_out[$];
    bit     obs_sat[$];
    longint m_res;
    bit     m_sat;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", a_acc_valid, 0);
            check("rst_out", $signed(a_acc_out), 0);
            check("rst_sat", a_acc_sat, 0);
            check("rst_mul_ready", a_mul_ready, 0);
            cur.delete();
            exp_out.delete();
            exp_sat.delete();
        end else begin
            check("acc_valid", a_acc_valid, exp_out.size() != 0);
            check("mul_ready", a_mul_ready,
                  !a_flush && !(cur.size() == VL_A - 1 && exp_out.size() != 0 && !a_acc_ready));
            if (a_acc_valid && exp_out.size() != 0) begin
                check("acc_out", $signed(a_acc_out), exp_out[0]);
                check("acc_sat", a_acc_sat, exp_sat[0]);
            end
            if (a_acc_valid && a_acc_ready) begin
                obs_out.push_back(longint'($signed(a_acc_out)));
                obs_sat.push_back(a_acc_sat);
                if (exp_out.size() != 0) begin
                    void'(exp_out.pop_front());
                    void'(exp_sat.pop_front());
                end
            end
            if (a_flush) begin
                cur.delete();
            end else if (a_mul_valid && a_mul_ready) begin
                cur.push_back(longint'($signed(a_mul_in)));
                if (cur.size() == VL_A) begin
                    ref_vec(cur, AW_A, m_res, m_sat);
                    exp_out.push_back(m_res);
                    exp_sat.push_back(m_sat);
                    cur.delete();
                end
            end
        end
    end

    task automatic send_a(input longint v);
        int k = 0;
        a_mul_in    = MW'(v);
        a_mul_valid = 1'b1;
        @(negedge clk);
        while (!a_mul_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("send_a_timeout", 1, 0);
        @(posedge clk);
        #1;
        a_mul_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_out.delete();
        obs_sat.delete();
    endtask

    task automatic run_s(input longint p[$], output longint o, output bit sat);
        int k;
        foreach (p[i]) begin
            s_mul_in    = MW'(p[i]);
            s_mul_valid = 1'b1;
            @(negedge clk);
            k = 0;
            while (!s_mul_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (k >= 20) check("send_s_timeout", 1, 0);
            @(posedge clk);
            #1;
        end
        s_mul_valid = 1'b0;
        k = 0;
        while (!s_acc_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("s_valid", s_acc_valid, 1);
        o   = longint'($signed(s_acc_out));
        sat = s_acc_sat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        longint p[$];
        longint o, mr;
        bit     sat, ms;
        int     t0;
        longint mx40, mn40;

        mx40 = (longint'(1) <<< 39) - 1;
        mn40 = -(longint'(1) <<< 39);

        rst = 1'b1;
        a_mul_in = '0; a_mul_valid = 1'b0; a_flush = 1'b0; a_acc_ready = 1'b1;
        s_mul_in = '0; s_mul_valid = 1'b0; s_flush = 1'b0; s_acc_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // basic sum
        clear_obs();
        send_a(3); send_a(-5); send_a(10); send_a(7);
        idle(3);
        check("basic_count", obs_out.size(), 1);
        if (obs_out.size() >= 1) begin
            check("basic_out", obs_out[0], 15);
            check("basic_sat", obs_sat[0], 0);
        end

        // back-to-back vectors
        clear_obs();
        t0 = cyc;
        for (int i = 1; i <= 8; i++) send_a(i);
        check("b2b_cycles", cyc - t0, 8);
        idle(3);
        check("b2b_count", obs_out.size(), 2);
        if (obs_out.size() >= 2) begin
            check("b2b_out0", obs_out[0], 10);
            check("b2b_out1", obs_out[1], 26);
        end

        // backpressure
        clear_obs();
        a_acc_ready = 1'b0;
        send_a(2); send_a(4); send_a(6); send_a(8);
        send_a(1); send_a(1); send_a(1);
        fork
            send_a(5);
            begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("bp_stall", a_mul_ready, 0);
                    check("bp_hold", $signed(a_acc_out), 20);
                end
                a_acc_ready = 1'b1;
            end
        join
        check("bp_next_valid", a_acc_valid, 1);
        check("bp_next_out", $signed(a_acc_out), 8);
        idle(3);
        check("bp_count", obs_out.size(), 2);
        if (obs_out.size() >= 2) begin
            check("bp_out0", obs_out[0], 20);
            check("bp_out1", obs_out[1], 8);
        end

        // flush
        clear_obs();
        a_flush = 1'b1;
        idle(1);
        a_flush = 1'b0;
        send_a(5); send_a(6);
        a_mul_in = MW'(100); a_mul_valid = 1'b1; a_flush = 1'b1;
        @(negedge clk);
        check("flush_ready", a_mul_ready, 0);
        @(posedge clk);
        #1;
        a_flush = 1'b0; a_mul_valid = 1'b0;
        send_a(1); send_a(1); send_a(1); send_a(1);
        idle(3);
        check("flush_count", obs_out.size(), 1);
        if (obs_out.size() >= 1) check("flush_out", obs_out[0], 4);

        // asynchronous reset mid-vector with a held result
        clear_obs();
        a_acc_ready = 1'b0;
        send_a(7); send_a(7); send_a(7); send_a(7);
        send_a(3); send_a(3);
        check("pre_rst_valid", a_acc_valid, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", a_acc_valid, 0);
        check("async_rst_out", $signed(a_acc_out), 0);
        check("async_rst_ready", a_mul_ready, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        a_acc_ready = 1'b1;
        idle(1);
        send_a(1); send_a(2); send_a(3); send_a(4);
        idle(3);
        check("rst_fresh_count", obs_out.size(), 1);
        if (obs_out.size() >= 1) check("rst_fresh_out", obs_out[0], 10);

        // randomized traffic with backpressure, flushes and boundary products
        clear_obs();
        for (int i = 0; i < 800; i++) begin
            a_mul_valid = ($urandom % 4) != 0;
            a_acc_ready = ($urandom % 3) != 0;
            a_flush     = ($urandom % 25) == 0;
            case ($urandom % 6)
                0:       a_mul_in = 32'h7FFF_FFFF;
                1:       a_mul_in = 32'h8000_0000;
                2:       a_mul_in = 32'h0000_0001;
                3:       a_mul_in = 32'hFFFF_FFFF;
                default: a_mul_in = $urandom;
            endcase
            idle(1);
        end
        a_mul_valid = 1'b0; a_flush = 1'b0; a_acc_ready = 1'b1;
        idle(4);
        check("rand_drained", exp_out.size(), 0);
        check("rand_enough_results", obs_out.size() > 50, 1);

        // positive saturation over a full 300-product vector
        p = {};
        for (int i = 0; i < VL_S; i++) p.push_back(longint'(32'h7FFF_FFFF));
        run_s(p, o, sat);
        check("sat_out", o, 64'sh7F_FFFF_FFFF);
        check("sat_flag", sat, 1);

        // normal vector afterwards must not inherit saturation
        p = {};
        for (int i = 0; i < VL_S; i++) p.push_back(longint'(i - 150));
        run_s(p, o, sat);
        check("normal_out", o, -150);
        check("normal_sat", sat, 0);

        // exactly max: 256 * (2^31-1) + 255
        p = {};
        for (int i = 0; i < 256; i++) p.push_back(longint'(32'h7FFF_FFFF));
        p.push_back(255);
        while (p.size() < VL_S) p.push_back(0);
        run_s(p, o, sat);
        check("exact_max_out", o, mx40);
        check("exact_max_sat", sat, 0);

        // exactly min: 256 * -2^31
        p = {};
        for (int i = 0; i < 256; i++) p.push_back(-(longint'(1) <<< 31));
        while (p.size() < VL_S) p.push_back(0);
        run_s(p, o, sat);
        check("exact_min_out", o, mn40);
        check("exact_min_sat", sat, 0);

        // negative saturation
        p = {};
        for (int i = 0; i < VL_S; i++) p.push_back(-(longint'(1) <<< 31));
        run_s(p, o, sat);
        check("neg_sat_out", o, mn40);
        check("neg_sat_flag", sat, 1);

        // saturation is sticky even after the sum comes back into range
        p = {};
        for (int i = 0; i < 257; i++) p.push_back(longint'(32'h7FFF_FFFF));
        while (p.size() < VL_S) p.push_back(-(longint'(1) <<< 31));
        ref_vec(p, AW_S, mr, ms);
        run_s(p, o, sat);
        check("sticky_out", o, mr);
        check("sticky_sat", sat, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Accumulation stage that sits directly downstream of the `Multiplier` inside `MAC`. It consumes the signed products on `mul_out`, sums a fixed-length vector of `VEC_LEN` products with saturation, and presents each dot-product result on a valid/ready output. A separate output register lets the next vector start accumulating while the previous result is still waiting to be taken.

## Interface
- `MUL_WIDTH`, 32: width of the signed product input.
- `ACC_WIDTH`, 40: width of the signed accumulator and result. Must satisfy `ACC_WIDTH >= MUL_WIDTH+1`.
- `VEC_LEN`, 8: number of products summed per result. Must be at least 1.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `mul_in`, input, `MUL_WIDTH`: two's-complement product from the `Multiplier`.
- `mul_valid`, input, 1: `mul_in` is valid this cycle.
- `mul_ready`, output, 1: the block accepts `mul_in` this cycle.
- `flush`, input, 1: abandon the vector currently being accumulated.
- `acc_out`, output, `ACC_WIDTH`: signed dot-product result.
- `acc_sat`, output, 1: `acc_out` was clamped during its accumulation.
- `acc_valid`, output, 1: `acc_out` and `acc_sat` are valid.
- `acc_ready`, input, 1: the consumer takes the result this cycle.

## Operation
- **Input handshake.** An input transfer occurs on a cycle where `mul_valid && mul_ready`. An output transfer occurs on a cycle where `acc_valid && acc_ready`.
- **Internal state.**
  - `sum`: running sum, `ACC_WIDTH` signed.
  - `cnt`: 0..VEC_LEN-1, the index of the next product.
  - `sat_r`: sticky saturation flag for the current vector.
- **Per-product update.** `mul_in` is sign-extended to `ACC_WIDTH`. The addend base is 0 when `cnt==0`, otherwise `sum`. This clears the accumulator automatically at the start of each vector. The addition is done at `ACC_WIDTH+1` bits.
- **Saturation.**
  - If the exact sum exceeds `2^(ACC_WIDTH-1)-1`, the result is clamped to that value.
  - If it is below `-2^(ACC_WIDTH-1)`, it is clamped to that value.
  - Either clamp sets `sat_r`, which stays set until the vector ends.
- **Non-last product** (`cnt < VEC_LEN-1`): `sum` takes the clamped result and `cnt` increments.
- **Last product** (`cnt == VEC_LEN-1`):
  - The clamped result loads `acc_out`.
  - `sat_r` OR the clamp of this last addition loads `acc_sat`.
  - `acc_valid` is set.
  - `cnt` returns to 0 and `sat_r` clears.
- **Output hold.** While `acc_valid && !acc_ready`, `acc_out` and `acc_sat` hold stable. `acc_valid` clears on an output transfer, unless a new last product is accepted in the same cycle, in which case it stays set with the new data.
- **mul_ready** is combinational: `!rst && !flush && !(cnt==VEC_LEN-1 && acc_valid && !acc_ready)`. Accumulation stalls only on the final product of a vector while the previous result is still occupied.
- **Flush.**
  - `flush` high clears `cnt` and `sat_r` at the edge. `sum` is don't-care, since it is re-based at `cnt==0`.
  - No product is accepted during flush.
  - The output register and `acc_valid` are unaffected.
- **VEC_LEN == 1.** Every product is a last product.

## Timing
- **Reset values:** `acc_out=0`, `acc_sat=0`, `acc_valid=0`, `cnt=0`, `sat_r=0`, `sum=0`. `mul_ready=0` while `rst` is high and 1 after release.
- **Reset mid-vector:** the partial sum is discarded and a held result is lost. There is no recovery.
- **Latency:** `acc_valid` rises on the first edge after the handshake of the last product. Sustained throughput is one product per cycle when `acc_ready` is held high.
- **Back-to-back vectors:** a last product accepted while the old result drains in the same cycle replaces it with no bubble.
- **Flush and valid in the same cycle:** flush wins. `mul_ready` is 0, so the product is not consumed.
- **Flush at `cnt==0`:** no effect.
- **Saturation boundary:** a result exactly equal to max or min is not saturated. `acc_sat=0`.

## Test plan
- **Basic sum.** `VEC_LEN=4`, products 3, -5, 10, 7 with no backpressure. Expect `acc_out=15` and `acc_sat=0`, with `acc_valid` high for 1 cycle, 1 cycle after the 4th handshake.
- **Back-to-back vectors.** Stream 8 products (1..8) continuously with `acc_ready=1`. Expect results 10 then 26, with `mul_ready` never low.
- **Backpressure.** `acc_ready=0` after the first result, then stream 4 more products. Expect:
  - `mul_ready` drops at the 4th product.
  - The first result holds stable.
  - Raising `acc_ready` accepts the 4th product in the same cycle.
  - The next result appears 1 cycle later.
- **Saturation.** `ACC_WIDTH=40`, `MUL_WIDTH=32`, products of 0x7FFFFFFF repeated for 300 items with `VEC_LEN=300`. Expect `acc_out=0x7FFFFFFFFF` and `acc_sat=1`. Then a normal vector, which must give `acc_sat=0`.
- **Flush.** Flush after 2 of 4 products, then send 1, 1, 1, 1. Expect `acc_out=4`, and the earlier partial sum never appears.
- **Reset mid-operation.** Assert `rst` asynchronously mid-vector with a result held. Expect all outputs 0 immediately, and the next 4 products to give a correct fresh result.
